// File: rtl/pipe_control_unit.sv
// pipe_control_unit: ID decode, load-use stall detection and control bundle pipeline through EX/MEM/WB
module pipe_control_unit #(
  parameter int ALUOP_W   = 2,
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 16,
  parameter bit BRANCH_EN = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [6:0]         Op_i,
  input  logic [REG_AW-1:0]  rs1_i,
  input  logic [REG_AW-1:0]  rs2_i,
  input  logic [REG_AW-1:0]  rd_i,
  input  logic               valid_i,
  input  logic               flush_i,
  output logic               Branch_o,
  output logic               stall_o,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic               ALUSrc_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic               RegWrite_o,
  output logic               MemToReg_o,
  output logic [REG_AW-1:0]  ex_rd_o,
  output logic [REG_AW-1:0]  mem_rd_o,
  output logic [REG_AW-1:0]  wb_rd_o,
  output logic               illegal_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   illegal_cnt_o
);
  logic               w_r, w_i, w_ld, w_st, w_br, w_legal, w_uses_rs2, w_load, w_regwrite;
  logic [ALUOP_W-1:0] w_aluop;
  logic [REG_AW-1:0]  w_rd;
  logic [ALUOP_W-1:0] r_ex_aluop;
  logic               r_ex_alusrc, r_ex_memread, r_ex_memwrite, r_ex_regwrite, r_ex_memtoreg, r_ex_illegal;
  logic [REG_AW-1:0]  r_ex_rd, r_mem_rd, r_wb_rd;
  logic               r_mem_memread, r_mem_memwrite, r_mem_regwrite, r_mem_memtoreg;
  logic               r_wb_regwrite, r_wb_memtoreg;
  logic [CNT_W-1:0]   r_stall_cnt, r_illegal_cnt;
  assign w_r        = Op_i == 7'b0110011;
  assign w_i        = Op_i == 7'b0010011;
  assign w_ld       = Op_i == 7'b0000011;
  assign w_st       = Op_i == 7'b0100011;
  assign w_br       = BRANCH_EN && (Op_i == 7'b1100011);
  assign w_legal    = w_r | w_i | w_ld | w_st | w_br;
  assign w_regwrite = w_r | w_i | w_ld;
  assign w_uses_rs2 = w_r | w_st | w_br;
  assign w_aluop    = w_br ? ALUOP_W'(3) : w_st ? ALUOP_W'(2) : (w_i | w_ld) ? ALUOP_W'(1) : '0;
  assign w_rd       = w_regwrite ? rd_i : '0;
  assign Branch_o   = valid_i & w_br;
  assign stall_o    = valid_i & r_ex_memread & (r_ex_rd != '0) &
                      ((r_ex_rd == rs1_i) | (w_uses_rs2 & (r_ex_rd == rs2_i)));
  assign w_load     = valid_i & ~stall_o & ~flush_i;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ex_aluop     <= '0;
      r_ex_alusrc    <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_ex_memwrite  <= 1'b0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memtoreg  <= 1'b0;
      r_ex_illegal   <= 1'b0;
      r_ex_rd        <= '0;
      r_mem_memread  <= 1'b0;
      r_mem_memwrite <= 1'b0;
      r_mem_regwrite <= 1'b0;
      r_mem_memtoreg <= 1'b0;
      r_mem_rd       <= '0;
      r_wb_regwrite  <= 1'b0;
      r_wb_memtoreg  <= 1'b0;
      r_wb_rd        <= '0;
      r_stall_cnt    <= '0;
      r_illegal_cnt  <= '0;
    end else begin
      r_ex_aluop     <= w_load ? w_aluop : '0;
      r_ex_alusrc    <= w_load & (w_i | w_ld | w_st);
      r_ex_memread   <= w_load & w_ld;
      r_ex_memwrite  <= w_load & w_st;
      r_ex_regwrite  <= w_load & w_regwrite;
      r_ex_memtoreg  <= w_load & w_ld;
      r_ex_illegal   <= w_load & ~w_legal;
      r_ex_rd        <= w_load ? w_rd : '0;
      r_mem_memread  <= r_ex_memread;
      r_mem_memwrite <= r_ex_memwrite;
      r_mem_regwrite <= r_ex_regwrite;
      r_mem_memtoreg <= r_ex_memtoreg;
      r_mem_rd       <= r_ex_rd;
      r_wb_regwrite  <= r_mem_regwrite;
      r_wb_memtoreg  <= r_mem_memtoreg;
      r_wb_rd        <= r_mem_rd;
      if (stall_o && !flush_i && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_load && !w_legal && !(&r_illegal_cnt)) r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
    end
  end
  assign ALUOp_o       = r_ex_aluop;
  assign ALUSrc_o      = r_ex_alusrc;
  assign illegal_o     = r_ex_illegal;
  assign ex_rd_o       = r_ex_rd;
  assign MemRead_o     = r_mem_memread;
  assign MemWrite_o    = r_mem_memwrite;
  assign mem_rd_o      = r_mem_rd;
  assign RegWrite_o    = r_wb_regwrite;
  assign MemToReg_o    = r_wb_memtoreg;
  assign wb_rd_o       = r_wb_rd;
  assign stall_cnt_o   = r_stall_cnt;
  assign illegal_cnt_o = r_illegal_cnt;
endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: directed vectors for decode, hazards, flush, reset and counter saturation
module tb_pipe_control_unit;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_BAD = 7'b1111111;
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] op = '0, op1 = '0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic valid = 1'b0, flush = 1'b0, valid1 = 1'b0;
  logic br, stall, alusrc, mrd, mwr, rwr, m2r, ill;
  logic [1:0] aluop;
  logic [4:0] exrd, memrd, wbrd;
  logic [15:0] scnt, icnt;
  logic br1, stall1, alusrc1, mrd1, mwr1, rwr1, m2r1, ill1;
  logic [1:0] aluop1, scnt1, icnt1;
  logic [4:0] exrd1, memrd1, wbrd1;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  pipe_control_unit u0 (
    .clk_i(clk), .rst_i(rst), .Op_i(op), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
    .valid_i(valid), .flush_i(flush), .Branch_o(br), .stall_o(stall), .ALUOp_o(aluop),
    .ALUSrc_o(alusrc), .MemRead_o(mrd), .MemWrite_o(mwr), .RegWrite_o(rwr), .MemToReg_o(m2r),
    .ex_rd_o(exrd), .mem_rd_o(memrd), .wb_rd_o(wbrd), .illegal_o(ill),
    .stall_cnt_o(scnt), .illegal_cnt_o(icnt)
  );
  pipe_control_unit #(.CNT_W(2), .BRANCH_EN(1'b0)) u1 (
    .clk_i(clk), .rst_i(rst), .Op_i(op1), .rs1_i(5'd1), .rs2_i(5'd2), .rd_i(5'd6),
    .valid_i(valid1), .flush_i(1'b0), .Branch_o(br1), .stall_o(stall1), .ALUOp_o(aluop1),
    .ALUSrc_o(alusrc1), .MemRead_o(mrd1), .MemWrite_o(mwr1), .RegWrite_o(rwr1), .MemToReg_o(m2r1),
    .ex_rd_o(exrd1), .mem_rd_o(memrd1), .wb_rd_o(wbrd1), .illegal_o(ill1),
    .stall_cnt_o(scnt1), .illegal_cnt_o(icnt1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [6:0] o, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic v, input logic f);
    op = o; rs1 = a; rs2 = b; rd = d; valid = v; flush = f;
    #1;
  endtask
  initial begin
    #2;
    chk("rst_aluop", aluop, 0);
    chk("rst_exrd", exrd, 0);
    chk("rst_stall", stall, 0);
    chk("rst_cnt", {scnt, icnt}, 0);
    tick(); tick();
    rst = 1'b0;
    drive(OP_R, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
    chk("r_stall", stall, 0);
    chk("r_branch", br, 0);
    tick();
    chk("r_ex", {aluop, alusrc, exrd}, {2'b00, 1'b0, 5'd5});
    chk("r_wb_early", rwr, 0);
    drive(OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    chk("r_mem", {mrd, mwr, memrd}, {2'b00, 5'd5});
    tick();
    chk("r_wb", {rwr, m2r, wbrd}, {2'b10, 5'd5});
    drive(OP_LD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    tick();
    chk("ld_ex", {aluop, alusrc, exrd}, {2'b01, 1'b1, 5'd3});
    drive(OP_R, 5'd3, 5'd6, 5'd7, 1'b1, 1'b0);
    chk("lu_stall", stall, 1);
    tick();
    chk("lu_bubble", {aluop, alusrc, ill, exrd}, 0);
    chk("lu_unstall", stall, 0);
    chk("lu_mem", {mrd, memrd}, {1'b1, 5'd3});
    chk("lu_scnt", scnt, 1);
    tick();
    chk("lu_ex", {aluop, alusrc, exrd}, {2'b00, 1'b0, 5'd7});
    chk("ld_wb", {rwr, m2r, wbrd}, {2'b11, 5'd3});
    drive(OP_LD, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
    tick();
    drive(OP_R, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
    chk("x0_stall", stall, 0);
    tick();
    drive(OP_LD, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0);
    tick();
    drive(OP_I, 5'd1, 5'd4, 5'd9, 1'b1, 1'b0);
    chk("i_rs2_stall", stall, 0);
    drive(OP_R, 5'd1, 5'd4, 5'd9, 1'b1, 1'b0);
    chk("r_rs2_stall", stall, 1);
    drive(OP_I, 5'd1, 5'd4, 5'd9, 1'b1, 1'b0);
    tick();
    chk("i_ex", {aluop, alusrc, exrd}, {2'b01, 1'b1, 5'd9});
    chk("i_scnt", scnt, 1);
    drive(OP_BR, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1);
    chk("br_comb", br, 1);
    tick();
    chk("br_flush_ex", {aluop, alusrc, ill, exrd}, 0);
    chk("br_icnt", icnt, 0);
    drive(OP_BR, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0);
    tick();
    chk("br_ex", {aluop, alusrc, exrd}, {2'b11, 1'b0, 5'd0});
    drive(OP_BAD, 5'd1, 5'd2, 5'd11, 1'b1, 1'b0);
    chk("bad_branch", br, 0);
    tick();
    chk("bad_ex", {ill, aluop, alusrc, exrd}, {1'b1, 2'b00, 1'b0, 5'd0});
    chk("bad_icnt", icnt, 1);
    drive(OP_BAD, 5'd1, 5'd2, 5'd11, 1'b1, 1'b1);
    tick();
    chk("bad_mem", {mrd, mwr}, 0);
    chk("bad_flush", {ill, icnt}, {1'b0, 16'd1});
    drive(OP_LD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    tick();
    drive(OP_R, 5'd3, 5'd2, 5'd7, 1'b1, 1'b1);
    chk("sf_stall", stall, 1);
    tick();
    chk("sf_bubble", {aluop, exrd}, 0);
    chk("sf_scnt", scnt, 1);
    drive(OP_ST, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0);
    tick();
    chk("st_ex", {aluop, alusrc, exrd}, {2'b10, 1'b1, 5'd0});
    drive(OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    chk("st_mem", {mwr, mrd, memrd}, {2'b10, 5'd0});
    #2;
    rst = 1'b1;
    #1;
    chk("arst_mwr", mwr, 0);
    chk("arst_cnt", {scnt, icnt}, 0);
    tick();
    rst = 1'b0;
    op1 = OP_BR; valid1 = 1'b1;
    #1;
    chk("u1_branch", br1, 0);
    tick();
    chk("u1_br_ill", {ill1, aluop1, exrd1}, {1'b1, 2'b00, 5'd0});
    chk("u1_icnt1", icnt1, 1);
    op1 = OP_BAD;
    tick(); tick();
    chk("u1_icnt3", icnt1, 3);
    tick();
    chk("u1_sat", icnt1, 3);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_control_unit.md
Name: pipe_control_unit

Overview:
- Pipelined successor to the single-cycle decoder for the 5-stage RISC-V core.
- Decodes the ID-stage opcode and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and inserts bubbles on stall or branch flush.
- Exports per-stage destination registers for the forwarding unit and saturating stall/illegal counters.

Parameters:
- ALUOP_W, 2, width of ALUOp bundle field.
- REG_AW, 5, register address width.
- CNT_W, 16, width of performance counters (saturating).
- BRANCH_EN, 1, 1 = decode BRANCH opcode; 0 = treat it as illegal.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  asynchronous active-high reset.
- Op_i  in  7  ID-stage opcode, instr[6:0].
- rs1_i  in  REG_AW  ID-stage rs1.
- rs2_i  in  REG_AW  ID-stage rs2.
- rd_i  in  REG_AW  ID-stage rd.
- valid_i  in  1  ID-stage holds a real instruction.
- flush_i  in  1  branch taken in ID; squash ID instruction.
- Branch_o  out  1  ID-stage combinational: opcode is BRANCH and valid_i.
- stall_o  out  1  combinational load-use stall; holds PC and IF/ID.
- ALUOp_o  out  ALUOP_W  EX-stage (registered).
- ALUSrc_o  out  1  EX-stage.
- MemRead_o  out  1  MEM-stage.
- MemWrite_o  out  1  MEM-stage.
- RegWrite_o  out  1  WB-stage.
- MemToReg_o  out  1  WB-stage.
- ex_rd_o / mem_rd_o / wb_rd_o  out  REG_AW each  rd per stage; 0 in a bubble.
- illegal_o  out  1  EX-stage: instruction was an undecodable opcode.
- stall_cnt_o  out  CNT_W  stall cycles since reset.
- illegal_cnt_o  out  CNT_W  illegal instructions since reset.

Behaviour:

Decode (combinational, ID):
- R 0110011: ALUOp 00, ALUSrc 0, RegWrite 1, others 0.
- I 0010011: ALUOp 01, ALUSrc 1, RegWrite 1.
- LOAD 0000011: ALUOp 01, ALUSrc 1, RegWrite 1, MemRead 1, MemToReg 1.
- STORE 0100011: ALUOp 10, ALUSrc 1, MemWrite 1, RegWrite 0.
- BRANCH 1100011 (BRANCH_EN=1): ALUOp 11, ALUSrc 0, no writes.
- Any other opcode with valid_i=1: all controls 0, illegal bit 1.
- rd carried as 0 for STORE, BRANCH and illegal opcodes.

Hazard detection:
- stall_o = valid_i & EX.MemRead & ex_rd≠0 & (ex_rd==rs1_i | (uses_rs2 & ex_rd==rs2_i)).
- uses_rs2 = R, STORE or BRANCH.

Pipeline update (every rising clk_i):
- ID/EX loads the bubble (all 0, rd 0, illegal 0) if stall_o, flush_i or !valid_i; otherwise it loads the decoded bundle.
- EX/MEM takes ID/EX unconditionally; MEM/WB takes EX/MEM unconditionally.
- No backpressure exists past ID.

Simultaneous events and counters:
- stall_o and flush_i together produce one bubble.
- stall_cnt increments on stall_o & !flush_i.
- illegal_cnt increments when an illegal instruction enters ID/EX (not stalled, not flushed).
- Both counters saturate at all-ones; no wrap.

Latency and reset:
- Decode of opcode at cycle N (not stalled) → EX outputs at N+1, MEM at N+2, WB at N+3.
- rst_i asserted asynchronously clears all stage registers and counters; every registered output reads 0 immediately.
- Combinational outputs follow inputs during reset; with ex_rd=0, stall_o is 0.
- Reset mid-stream discards all in-flight controls; no partial writes survive.

Test Plan:
- Reset, then R-type at cycle 0 with rd=5 → ALUOp_o=00 at cycle 1; RegWrite_o=1, MemToReg_o=0, wb_rd_o=5 at cycle 3.
- LOAD rd=3, then R-type with rs1=3 → stall_o=1 for exactly one cycle; EX holds a bubble (all 0) one cycle; the R-type reaches EX a cycle later; stall_cnt_o=1.
- LOAD rd=0, then dependent on x0 → no stall. LOAD rd=4, then I-type with rs2 field=4 → no stall, since I-type does not use rs2.
- BRANCH with flush_i=1 → Branch_o=1 combinationally; next-cycle EX controls all 0; illegal_cnt_o unchanged.
- Opcode 1111111 valid → illegal_o=1 at EX, all write/mem controls 0, illegal_cnt_o=1. With BRANCH_EN=0, 1100011 → illegal.
- Assert rst_i asynchronously mid-cycle while MEM holds a STORE → MemWrite_o drops to 0 without waiting for a clock edge; counters read 0.
- Force illegal_cnt to all-ones and issue one more illegal → count stays at all-ones.
